// File: rtl/alu_unit_if.sv
// alu_unit_if: bundles the op-issue bus from the reservation station and the
// CDB/fetch-redirect results coming back from the ALU.
//   master : RS side   -- drives execute/op_type/val1/val2/entry/nowPC,
//                         receives aluReady/entry_out/val_out/alu2if_pc/alu2if_con
//   slave  : ALU side  -- the mirror image
// The op code is named op_type because "type" is a reserved word in SystemVerilog.
interface alu_unit_if #(
  parameter int VAL_WIDTH    = 32,
  parameter int OP_WIDTH     = 7,
  parameter int ROB_ID_WIDTH = 4,
  parameter int ADDR_WIDTH   = 32
);
  logic                    execute;
  logic [OP_WIDTH-1:0]     op_type;
  logic [VAL_WIDTH-1:0]    val1;
  logic [VAL_WIDTH-1:0]    val2;
  logic [ROB_ID_WIDTH:0]   entry;
  logic [ADDR_WIDTH-1:0]   nowPC;
  logic                    aluReady;
  logic [ROB_ID_WIDTH:0]   entry_out;
  logic [VAL_WIDTH-1:0]    val_out;
  logic [ADDR_WIDTH-1:0]   alu2if_pc;
  logic                    alu2if_con;

  modport master (
    output execute, op_type, val1, val2, entry, nowPC,
    input  aluReady, entry_out, val_out, alu2if_pc, alu2if_con
  );

  modport slave (
    input  execute, op_type, val1, val2, entry, nowPC,
    output aluReady, entry_out, val_out, alu2if_pc, alu2if_con
  );
endinterface

// File: rtl/alu_unit.sv
// alu_unit: single-cycle RV32I integer execute unit.
// Computes the result of one op combinationally and registers it onto the CDB
// slot one clock later; JALR additionally produces a redirect target and a
// one-cycle resume pulse for instruction fetch.
// Ports:
//   clk     rising-edge clock
//   rst_in  asynchronous active-low reset; clears every output immediately
//   rdy_in  global enable; when low all state is frozen
//   flush   mispredict flush, acts only when rdy_in is high
//   bus     alu_unit_if.slave: op issue in, CDB result / fetch redirect out
module alu_unit #(
  parameter int VAL_WIDTH    = 32,
  parameter int OP_WIDTH     = 7,
  parameter int ROB_ID_WIDTH = 4,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       flush,
  alu_unit_if.slave  bus
);

  localparam int SHAMT_W = $clog2(VAL_WIDTH);

  // Op classes (op_type[6:4])
  localparam logic [2:0] CLS_R     = 3'd0;
  localparam logic [2:0] CLS_I     = 3'd1;
  localparam logic [2:0] CLS_BR    = 3'd2;
  localparam logic [2:0] CLS_LUI   = 3'd3;
  localparam logic [2:0] CLS_AUIPC = 3'd4;
  localparam logic [2:0] CLS_JAL   = 3'd5;
  localparam logic [2:0] CLS_JALR  = 3'd6;

  logic [2:0]             op_class;
  logic [3:0]             sub_op;
  logic [SHAMT_W-1:0]     shamt;
  logic [VAL_WIDTH-1:0]   sum;
  logic [VAL_WIDTH-1:0]   diff;
  logic [VAL_WIDTH-1:0]   sra_val;
  logic [VAL_WIDTH-1:0]   jalr_target;
  logic                   lt_s;
  logic                   lt_u;
  logic                   taken;
  logic [VAL_WIDTH-1:0]   arith_val;
  logic [VAL_WIDTH-1:0]   result;

  logic                   ready_reg;
  logic [ROB_ID_WIDTH:0]  entry_reg;
  logic [VAL_WIDTH-1:0]   val_reg;
  logic [ADDR_WIDTH-1:0]  pc_reg;
  logic                   con_reg;

  // nowPC is carried on the bus for future use but takes no part in compute.
  logic unused_now_pc;
  assign unused_now_pc = ^bus.nowPC;

  assign op_class    = bus.op_type[6:4];
  assign sub_op      = bus.op_type[3:0];
  assign shamt       = bus.val2[SHAMT_W-1:0];
  assign sum         = bus.val1 + bus.val2;
  assign diff        = bus.val1 - bus.val2;
  assign sra_val     = VAL_WIDTH'($signed(bus.val1) >>> shamt);
  assign lt_s        = $signed(bus.val1) < $signed(bus.val2);
  assign lt_u        = bus.val1 < bus.val2;
  assign jalr_target = sum & ~VAL_WIDTH'(1);

  // R-type and I-arith share the sub-op decode; SUB only exists for R-type,
  // so an I-arith sub-op 1 falls through to the unknown case (result 0).
  always_comb begin
    arith_val = '0;
    case (sub_op)
      4'd0: arith_val = sum;
      4'd1: arith_val = (op_class == CLS_R) ? diff : '0;
      4'd2: arith_val = bus.val1 << shamt;
      4'd3: arith_val = {{(VAL_WIDTH-1){1'b0}}, lt_s};
      4'd4: arith_val = {{(VAL_WIDTH-1){1'b0}}, lt_u};
      4'd5: arith_val = bus.val1 ^ bus.val2;
      4'd6: arith_val = bus.val1 >> shamt;
      4'd7: arith_val = sra_val;
      4'd8: arith_val = bus.val1 | bus.val2;
      4'd9: arith_val = bus.val1 & bus.val2;
      default: arith_val = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (sub_op)
      4'd0: taken = (bus.val1 == bus.val2);
      4'd1: taken = (bus.val1 != bus.val2);
      4'd2: taken = lt_s;
      4'd3: taken = !lt_s;
      4'd4: taken = lt_u;
      4'd5: taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    result = '0;
    case (op_class)
      CLS_R, CLS_I:       result = arith_val;
      CLS_BR:             result = {{(VAL_WIDTH-1){1'b0}}, taken};
      CLS_LUI:            result = bus.val1;
      CLS_AUIPC, CLS_JAL: result = sum;
      CLS_JALR:           result = jalr_target;
      default:            result = '0;
    endcase
  end

  // Flush clears the CDB slot and drops any op issued in the same cycle;
  // alu2if_pc is left alone since alu2if_con already qualifies it.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      ready_reg <= 1'b0;
      entry_reg <= '0;
      val_reg   <= '0;
      pc_reg    <= '0;
      con_reg   <= 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        ready_reg <= 1'b0;
        entry_reg <= '0;
        val_reg   <= '0;
        con_reg   <= 1'b0;
      end else if (bus.execute) begin
        ready_reg <= 1'b1;
        entry_reg <= bus.entry;
        val_reg   <= result;
        if (op_class == CLS_JALR) begin
          pc_reg  <= jalr_target[ADDR_WIDTH-1:0];
          con_reg <= 1'b1;
        end else begin
          con_reg <= 1'b0;
        end
      end else begin
        ready_reg <= 1'b0;
        con_reg   <= 1'b0;
      end
    end
  end

  assign bus.aluReady   = ready_reg;
  assign bus.entry_out  = entry_reg;
  assign bus.val_out    = val_reg;
  assign bus.alu2if_pc  = pc_reg;
  assign bus.alu2if_con = con_reg;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed, table-driven bench for alu_unit plus hand-written
// sequences for reset, idle, stall, flush and JALR pulse behaviour.
module tb_alu_unit;

  logic clk;
  logic rst_in;
  logic rdy_in;
  logic flush;

  int checks;
  int failures;

  alu_unit_if #(.VAL_WIDTH(32), .OP_WIDTH(7), .ROB_ID_WIDTH(4), .ADDR_WIDTH(32)) bus ();

  alu_unit #(.VAL_WIDTH(32), .OP_WIDTH(7), .ROB_ID_WIDTH(4), .ADDR_WIDTH(32)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  tag;
    logic [31:0] exp_val;
    logic        exp_con;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic ex, input logic [6:0] op, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [4:0] tag);
    bus.execute = ex;
    bus.op_type = op;
    bus.val1    = v1;
    bus.val2    = v2;
    bus.entry   = tag;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".aluReady"},   32'(bus.aluReady),   32'd0);
    chk({name, ".entry_out"},  32'(bus.entry_out),  32'd0);
    chk({name, ".val_out"},    bus.val_out,         32'd0);
    chk({name, ".alu2if_pc"},  bus.alu2if_pc,       32'd0);
    chk({name, ".alu2if_con"}, 32'(bus.alu2if_con), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{"ADD",        7'h00, 32'd5,        32'd7,        5'd3,  32'd12,       1'b0};
    vecs[1]  = '{"SUB",        7'h01, 32'd0,        32'd1,        5'd4,  32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{"SLL_sh35",   7'h02, 32'd1,        32'd35,       5'd5,  32'd8,        1'b0};
    vecs[3]  = '{"SLT",        7'h03, 32'hFFFFFFFF, 32'd1,        5'd6,  32'd1,        1'b0};
    vecs[4]  = '{"SLTU",       7'h04, 32'hFFFFFFFF, 32'd1,        5'd7,  32'd0,        1'b0};
    vecs[5]  = '{"XOR",        7'h05, 32'h0000F0F0, 32'h0000FF00, 5'd8,  32'h00000FF0, 1'b0};
    vecs[6]  = '{"SRL",        7'h06, 32'h80000000, 32'd4,        5'd9,  32'h08000000, 1'b0};
    vecs[7]  = '{"SRA",        7'h07, 32'h80000000, 32'd4,        5'd10, 32'hF8000000, 1'b0};
    vecs[8]  = '{"OR",         7'h08, 32'h000000F0, 32'h0000000F, 5'd11, 32'h000000FF, 1'b0};
    vecs[9]  = '{"AND",        7'h09, 32'h000000F0, 32'h0000003C, 5'd12, 32'h00000030, 1'b0};
    vecs[10] = '{"ADDI_wrap",  7'h10, 32'hFFFFFFFF, 32'd2,        5'd13, 32'd1,        1'b0};
    vecs[11] = '{"ISUB_unk",   7'h11, 32'd9,        32'd1,        5'd14, 32'd0,        1'b0};
    vecs[12] = '{"BEQ",        7'h20, 32'd2,        32'd3,        5'd15, 32'd0,        1'b0};
    vecs[13] = '{"BNE",        7'h21, 32'd2,        32'd3,        5'd16, 32'd1,        1'b0};
    vecs[14] = '{"BLT",        7'h22, 32'hFFFFFFFF, 32'd1,        5'd17, 32'd1,        1'b0};
    vecs[15] = '{"BGE",        7'h23, 32'hFFFFFFFF, 32'd1,        5'd18, 32'd0,        1'b0};
    vecs[16] = '{"BLTU",       7'h24, 32'hFFFFFFFF, 32'd1,        5'd19, 32'd0,        1'b0};
    vecs[17] = '{"BGEU",       7'h25, 32'hFFFFFFFF, 32'd1,        5'd20, 32'd1,        1'b0};
    vecs[18] = '{"BR_unk",     7'h26, 32'd5,        32'd5,        5'd21, 32'd0,        1'b0};
    vecs[19] = '{"LUI",        7'h30, 32'h12345000, 32'd99,       5'd22, 32'h12345000, 1'b0};
    vecs[20] = '{"AUIPC",      7'h40, 32'h00001000, 32'h00000020, 5'd23, 32'h00001020, 1'b0};
    vecs[21] = '{"JAL",        7'h50, 32'h00002000, 32'h00000004, 5'd24, 32'h00002004, 1'b0};
    vecs[22] = '{"JALR",       7'h60, 32'h00001003, 32'd4,        5'd25, 32'h00001006, 1'b1};
    vecs[23] = '{"CLS_unk",    7'h70, 32'd7,        32'd8,        5'd26, 32'd0,        1'b0};
    vecs[24] = '{"R_unk_sub",  7'h0A, 32'd7,        32'd8,        5'd31, 32'd0,        1'b0};

    rst_in      = 1'b0;
    rdy_in      = 1'b1;
    flush       = 1'b0;
    bus.execute = 1'b0;
    bus.op_type = '0;
    bus.val1    = '0;
    bus.val2    = '0;
    bus.entry   = '0;
    bus.nowPC   = 32'h0000_4000;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_in = 1'b1;

    // ADD then an idle cycle: valid drops, tag/value hold
    issue(1'b1, 7'h00, 32'd5, 32'd7, 5'd3);
    chk("add.aluReady",  32'(bus.aluReady),  32'd1);
    chk("add.entry_out", 32'(bus.entry_out), 32'd3);
    chk("add.val_out",   bus.val_out,        32'd12);
    issue(1'b0, 7'h00, 32'd0, 32'd0, 5'd0);
    chk("idle.aluReady",  32'(bus.aluReady),  32'd0);
    chk("idle.entry_out", 32'(bus.entry_out), 32'd3);
    chk("idle.val_out",   bus.val_out,        32'd12);

    // Table, applied back to back
    foreach (vecs[i]) begin
      issue(1'b1, vecs[i].op, vecs[i].v1, vecs[i].v2, vecs[i].tag);
      $display("vec %-10s tag=%0d val_out=0x%08h con=%0d", vecs[i].name, vecs[i].tag,
               bus.val_out, bus.alu2if_con);
      chk({vecs[i].name, ".aluReady"},   32'(bus.aluReady),   32'd1);
      chk({vecs[i].name, ".entry_out"},  32'(bus.entry_out),  32'(vecs[i].tag));
      chk({vecs[i].name, ".val_out"},    bus.val_out,         vecs[i].exp_val);
      chk({vecs[i].name, ".alu2if_con"}, 32'(bus.alu2if_con), 32'(vecs[i].exp_con));
      if (vecs[i].exp_con)
        chk({vecs[i].name, ".alu2if_pc"}, bus.alu2if_pc, vecs[i].exp_val);
    end

    // JALR pulse lasts one cycle; target holds afterwards
    issue(1'b1, 7'h60, 32'h00001003, 32'd4, 5'd2);
    chk("jalr.con",  32'(bus.alu2if_con), 32'd1);
    chk("jalr.pc",   bus.alu2if_pc,       32'h00001006);
    issue(1'b0, 7'h00, 32'd0, 32'd0, 5'd0);
    chk("jalr_idle.con", 32'(bus.alu2if_con), 32'd0);
    chk("jalr_idle.pc",  bus.alu2if_pc,       32'h00001006);

    // Stall: rdy_in=0 freezes outputs, with execute and with flush
    issue(1'b1, 7'h00, 32'd5, 32'd7, 5'd3);
    rdy_in = 1'b0;
    issue(1'b1, 7'h01, 32'd9, 32'd1, 5'd7);
    chk("stall.aluReady",  32'(bus.aluReady),  32'd1);
    chk("stall.entry_out", 32'(bus.entry_out), 32'd3);
    chk("stall.val_out",   bus.val_out,        32'd12);
    flush = 1'b1;
    issue(1'b1, 7'h01, 32'd9, 32'd1, 5'd7);
    chk("stall_flush.aluReady", 32'(bus.aluReady), 32'd1);
    chk("stall_flush.val_out",  bus.val_out,       32'd12);
    rdy_in = 1'b1;

    // Flush with execute: op dropped, slot cleared
    issue(1'b1, 7'h00, 32'd5, 32'd7, 5'd9);
    flush = 1'b0;
    chk("flush.aluReady",  32'(bus.aluReady),  32'd0);
    chk("flush.entry_out", 32'(bus.entry_out), 32'd0);
    chk("flush.val_out",   bus.val_out,        32'd0);
    chk("flush.con",       32'(bus.alu2if_con), 32'd0);

    // Back-to-back tags 1 and 2
    issue(1'b1, 7'h00, 32'd10, 32'd1, 5'd1);
    chk("b2b1.aluReady",  32'(bus.aluReady),  32'd1);
    chk("b2b1.entry_out", 32'(bus.entry_out), 32'd1);
    chk("b2b1.val_out",   bus.val_out,        32'd11);
    issue(1'b1, 7'h00, 32'd20, 32'd2, 5'd2);
    chk("b2b2.aluReady",  32'(bus.aluReady),  32'd1);
    chk("b2b2.entry_out", 32'(bus.entry_out), 32'd2);
    chk("b2b2.val_out",   bus.val_out,        32'd22);

    // Asynchronous reset mid-op clears everything before the next edge
    issue(1'b1, 7'h60, 32'h00001003, 32'd4, 5'd5);
    #2;
    rst_in = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk);
    #1;
    chk_all_zero("reset_held");
    rst_in      = 1'b1;
    bus.execute = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
